// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core: one round per clock, 16-word schedule window, H chaining.
// Optional macro SHA256_ABORT_EN adds an abort input that returns the core to IDLE with H reset to IV.
//
// state  | meaning
// IDLE   | waiting for a block; block_ready=1
// ROUND  | one compression round per cycle, cnt = round index
// UPDATE | fold working variables into H
// DONE   | digest_valid=1 until digest_ready
module sha256_iter_core #(
  parameter int NUM_ROUNDS = 64,
  parameter int CNT_W      = 6
) (
  input  logic         clk,
  input  logic         reset,
`ifdef SHA256_ABORT_EN
  input  logic         abort,
`endif
  input  logic [511:0] block_in,
  input  logic         block_first,
  input  logic         block_last,
  input  logic         block_valid,
  output logic         block_ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, DONE} state_t;

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t      state;
  logic [CNT_W-1:0] cnt;
  logic        last_flag;
  logic [31:0] h_reg [0:7];
  logic [31:0] wv    [0:7];
  logic [31:0] w     [0:15];

  logic [31:0] big_s0, big_s1, ch, maj, t1, t2, sm_s0, sm_s1, w_new;

  // Working variables wv[0..7] are a..h.
  always_comb begin
    big_s1 = rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25);
    ch     = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
    t1     = wv[7] + big_s1 + ch + K_ROM[cnt] + w[0];
    big_s0 = rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22);
    maj    = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
    t2     = big_s0 + maj;
    sm_s0  = rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3);
    sm_s1  = rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10);
    w_new  = sm_s1 + w[9] + sm_s0 + w[0];
  end

  assign digest = {h_reg[0], h_reg[1], h_reg[2], h_reg[3],
                   h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_flag    <= 1'b0;
      block_ready  <= 1'b1;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_reg[i] <= IV[i];
        wv[i]    <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
`ifdef SHA256_ABORT_EN
      if (abort) begin
        state        <= IDLE;
        cnt          <= '0;
        block_ready  <= 1'b1;
        digest_valid <= 1'b0;
        busy         <= 1'b0;
        for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
      end else
`endif
      case (state)
        IDLE: begin
          if (block_valid && block_ready) begin
            for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              if (block_first) begin
                h_reg[i] <= IV[i];
                wv[i]    <= IV[i];
              end else begin
                wv[i]    <= h_reg[i];
              end
            end
            last_flag   <= block_last;
            cnt         <= '0;
            state       <= ROUND;
            block_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        ROUND: begin
          wv[0] <= t1 + t2;
          wv[1] <= wv[0];
          wv[2] <= wv[1];
          wv[3] <= wv[2];
          wv[4] <= wv[3] + t1;
          wv[5] <= wv[4];
          wv[6] <= wv[5];
          wv[7] <= wv[6];
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          if (cnt == CNT_W'(NUM_ROUNDS - 1)) begin
            cnt   <= '0;
            state <= UPDATE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + wv[i];
          if (last_flag) begin
            state        <= DONE;
            digest_valid <= 1'b1;
          end else begin
            state       <= IDLE;
            block_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        DONE: begin
          if (digest_ready) begin
            state        <= IDLE;
            digest_valid <= 1'b0;
            block_ready  <= 1'b1;
            busy         <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          block_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Directed bench for sha256_iter_core: known-answer digests, latency, back-pressure, reset and abort.
module tb_sha256_iter_core;

  logic         clk;
  logic         reset;
  logic [511:0] block_in;
  logic         block_first;
  logic         block_last;
  logic         block_valid;
  logic         block_ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;
`ifdef SHA256_ABORT_EN
  logic         abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [255:0] IV_D  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] B_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMP = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TW1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TW2 = {480'h0, 32'h000001c0};

  sha256_iter_core dut (
    .clk          (clk),
    .reset        (reset),
`ifdef SHA256_ABORT_EN
    .abort        (abort),
`endif
    .block_in     (block_in),
    .block_first  (block_first),
    .block_last   (block_last),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .digest       (digest),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 256'(block_ready), 256'(1));
    check({tag, "_dv"}, 256'(digest_valid), 256'(0));
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_digest"}, digest, IV_D);
  endtask

  // Presents one block for a single cycle; the next posedge is the accept edge.
  task automatic send_block(input logic [511:0] blk, input logic first, input logic last);
    int guard = 0;
    while (block_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_send", 256'(block_ready), 256'(1));
    block_in    = blk;
    block_first = first;
    block_last  = last;
    block_valid = 1'b1;
    @(posedge clk); #1;
    block_valid = 1'b0;
    check("busy_after_accept", 256'(busy), 256'(1));
  endtask

  // Call right after the accept edge; checks the exact 65-edge latency to digest_valid.
  task automatic expect_digest(input string tag, input logic [255:0] exp);
    repeat (64) @(posedge clk);
    #1;
    check({tag, "_dv_early"}, 256'(digest_valid), 256'(0));
    @(posedge clk); #1;
    check({tag, "_dv"}, 256'(digest_valid), 256'(1));
    check({tag, "_digest"}, digest, exp);
  endtask

  task automatic take_digest(input string tag);
    digest_ready = 1'b1;
    @(posedge clk); #1;
    digest_ready = 1'b0;
    check({tag, "_dv_drop"}, 256'(digest_valid), 256'(0));
    check({tag, "_ready_back"}, 256'(block_ready), 256'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] junk;
    reset        = 1'b1;
    block_in     = '0;
    block_first  = 1'b0;
    block_last   = 1'b0;
    block_valid  = 1'b0;
    digest_ready = 1'b0;
`ifdef SHA256_ABORT_EN
    abort        = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // "abc"
    send_block(B_ABC, 1'b1, 1'b1);
    expect_digest("abc", D_ABC);
    take_digest("abc");

    // empty message with consumer stalling
    send_block(B_EMP, 1'b1, 1'b1);
    expect_digest("empty", D_EMP);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_digest", digest, D_EMP);
      check("stall_ready", 256'(block_ready), 256'(0));
      check("stall_dv", 256'(digest_valid), 256'(1));
    end
    take_digest("empty");

    // two-block message
    send_block(B_TW1, 1'b1, 1'b0);
    repeat (65) @(posedge clk);
    #1;
    check("two_blk1_dv", 256'(digest_valid), 256'(0));
    check("two_blk1_ready", 256'(block_ready), 256'(1));
    send_block(B_TW2, 1'b0, 1'b1);
    expect_digest("two", D_TWO);
    take_digest("two");

    // reset in the middle of ROUND
    send_block(B_ABC, 1'b1, 1'b1);
    repeat (30) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check_reset_outputs("midrst_hold");
    reset = 1'b0;
    @(posedge clk); #1;
    send_block(B_ABC, 1'b1, 1'b1);
    expect_digest("abc_after_rst", D_ABC);
    take_digest("abc_after_rst");

    // block_valid held during ROUND with garbage data
    block_in    = B_ABC;
    block_first = 1'b1;
    block_last  = 1'b1;
    block_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 65; c++) begin
      for (int j = 0; j < 16; j++) junk[32*j +: 32] = $urandom;
      block_in    = junk;
      block_first = c[0];
      block_last  = c[1];
      @(posedge clk); #1;
    end
    block_valid = 1'b0;
    check("held_valid_dv", 256'(digest_valid), 256'(1));
    check("held_valid_digest", digest, D_ABC);
    take_digest("held_valid");

`ifdef SHA256_ABORT_EN
    begin
      int pulses = 0;
      send_block(B_ABC, 1'b1, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_reset_outputs("abort");
      for (int i = 0; i < 70; i++) begin
        @(posedge clk); #1;
        if (digest_valid === 1'b1) pulses++;
      end
      check("abort_no_dv", 256'(pulses), 256'(0));
      send_block(B_ABC, 1'b1, 1'b1);
      expect_digest("abc_after_abort", D_ABC);
      take_digest("abc_after_abort");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
